umi_arbiter_rr: RTL and testbench

// - N-requester UMI arbiter feeding one shared UMI channel (the input side of a width-converting UMI FIFO).
// - Packet-atomic: a granted requester keeps the channel until a beat with cmd EOM=1 is accepted.
// - Round-robin fairness between packets; optional QoS-first selection.
// - Single clock domain (umi_in_clk); output is a zero-latency mux of the granted input.

---
 rtl/umi_pkg.sv | 15 +
 rtl/umi_arb_rr_pick.sv | 33 +++
 rtl/umi_unpack.sv | 21 ++
 rtl/umi_arbiter_rr.sv | 195 +++++++++++++++++++
 tb/tb_umi_arbiter_rr.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/umi_pkg.sv
// UMI field positions and arbiter state encoding shared by the arbiter slice.
package umi_pkg;

    // UMI command word field positions
    localparam int UMI_QOS_LSB = 16;
    localparam int UMI_QOS_W   = 4;
    localparam int UMI_EOM_BIT = 22;

    // Arbiter state encoding
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/umi_arb_rr_pick.sv
// Masked round-robin priority encoder: first set request at or after rr_ptr (modulo N).
module umi_arb_rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic [N-1:0]  grant_oh,
    output logic [IW-1:0] grant_idx,
    output logic          grant_any
);

    // Scan the requesters starting at rr_ptr and take the first one asserted
    always_comb begin
        int            sum_v;
        logic [IW-1:0] pos_v;
        grant_oh  = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int off = 0; off < N; off++) begin
            sum_v = int'(rr_ptr) + off;
            pos_v = (sum_v >= N) ? IW'(sum_v - N) : IW'(sum_v);
            if (!grant_any && req[pos_v]) begin
                grant_any       = 1'b1;
                grant_oh[pos_v] = 1'b1;
                grant_idx       = pos_v;
            end else begin
                grant_any = grant_any;
            end
        end
    end

endmodule

// File: rtl/umi_unpack.sv
// Extracts the UMI command fields the arbiter needs (end-of-message, QoS).
module umi_unpack
    import umi_pkg::*;
#(
    parameter int CW = 32
) (
    input  logic [CW-1:0]        packet_cmd,
    output logic                 cmd_eom,
    output logic [UMI_QOS_W-1:0] cmd_qos
);

    // Fields not used by the arbiter are folded into a sink
    logic unused_cmd_s;

    assign cmd_eom      = packet_cmd[UMI_EOM_BIT];
    assign cmd_qos      = packet_cmd[UMI_QOS_LSB +: UMI_QOS_W];
    assign unused_cmd_s = ^{packet_cmd[CW-1:UMI_EOM_BIT+1],
                            packet_cmd[UMI_EOM_BIT-1:UMI_QOS_LSB+UMI_QOS_W],
                            packet_cmd[UMI_QOS_LSB-1:0]};

endmodule

// File: rtl/umi_arbiter_rr.sv
// Packet-atomic round-robin arbiter merging N UMI requesters onto one channel.
// A requester that presents a beat keeps the channel until a beat with EOM=1
// is accepted. Define UMI_ARB_QOS_EN to restrict each new arbitration to the
// requesters carrying the highest QoS value.
module umi_arbiter_rr
    import umi_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = 32,
    parameter int AW = 64,
    parameter int DW = 256
) (
    input  logic          umi_in_clk,
    input  logic          umi_in_nreset,
    input  logic [N-1:0]    umi_req_valid,
    input  logic [N*CW-1:0] umi_req_cmd,
    input  logic [N*AW-1:0] umi_req_dstaddr,
    input  logic [N*AW-1:0] umi_req_srcaddr,
    input  logic [N*DW-1:0] umi_req_data,
    output logic [N-1:0]    umi_req_ready,
    output logic            umi_out_valid,
    output logic [CW-1:0]   umi_out_cmd,
    output logic [AW-1:0]   umi_out_dstaddr,
    output logic [AW-1:0]   umi_out_srcaddr,
    output logic [DW-1:0]   umi_out_data,
    input  logic            umi_out_ready,
    output logic [N-1:0]    arb_grant,
    output logic            arb_locked
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    arb_state_t    state_r;
    arb_state_t    state_nxt_s;
    logic [IW-1:0] owner_r;
    logic [IW-1:0] owner_nxt_s;
    logic [IW-1:0] rr_ptr_r;
    logic [IW-1:0] rr_ptr_nxt_s;
    logic [1:0]    init_r;

    logic [N-1:0]                eom_vec_s;
    logic [N-1:0][UMI_QOS_W-1:0] qos_vec_s;
    logic [N-1:0]                cand_s;
    logic [N-1:0]                pick_oh_s;
    logic [IW-1:0]               pick_idx_s;
    logic                        pick_any_s;
    logic [N-1:0]                grant_s;
    logic [IW-1:0]               grant_idx_s;
    logic                        out_valid_s;
    logic                        accept_s;
    logic                        eom_s;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] idx);
        logic [IW-1:0] res;
        if (idx == IW'(N - 1)) begin
            res = '0;
        end else begin
            res = idx + IW'(1);
        end
        return res;
    endfunction

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_unpack
            umi_unpack #(.CW(CW)) u_unpack (
                .packet_cmd (umi_req_cmd[g*CW +: CW]),
                .cmd_eom    (eom_vec_s[g]),
                .cmd_qos    (qos_vec_s[g])
            );
        end
    endgenerate

`ifdef UMI_ARB_QOS_EN
    logic [UMI_QOS_W-1:0] qos_max_s;

    // Highest QoS among valid requesters, then keep only those at that level
    always_comb begin
        qos_max_s = '0;
        for (int i = 0; i < N; i++) begin
            if (umi_req_valid[i] && (qos_vec_s[i] > qos_max_s)) begin
                qos_max_s = qos_vec_s[i];
            end else begin
                qos_max_s = qos_max_s;
            end
        end
        for (int i = 0; i < N; i++) begin
            cand_s[i] = umi_req_valid[i] && (qos_vec_s[i] == qos_max_s);
        end
    end
`else
    logic unused_qos_s;

    assign cand_s       = umi_req_valid;
    assign unused_qos_s = ^qos_vec_s;
`endif

    umi_arb_rr_pick #(.N(N), .IW(IW)) u_pick (
        .req       (cand_s),
        .rr_ptr    (rr_ptr_r),
        .grant_oh  (pick_oh_s),
        .grant_idx (pick_idx_s),
        .grant_any (pick_any_s)
    );

    // State, owner, round-robin pointer and init shifter
    always_ff @(posedge umi_in_clk or negedge umi_in_nreset) begin
        if (!umi_in_nreset) begin
            state_r  <= IDLE;
            owner_r  <= '0;
            rr_ptr_r <= '0;
            init_r   <= 2'b00;
        end else begin
            state_r  <= state_nxt_s;
            owner_r  <= owner_nxt_s;
            rr_ptr_r <= rr_ptr_nxt_s;
            init_r   <= {init_r[0], 1'b1};
        end
    end

    // Grant selection: owner while locked, fresh round-robin pick while idle
    always_comb begin
        grant_s     = '0;
        grant_idx_s = '0;
        if (!init_r[1]) begin
            grant_s     = '0;
            grant_idx_s = '0;
        end else if (state_r == LOCKED) begin
            grant_s[owner_r] = 1'b1;
            grant_idx_s      = owner_r;
        end else if (pick_any_s) begin
            grant_s     = pick_oh_s;
            grant_idx_s = pick_idx_s;
        end else begin
            grant_s     = '0;
            grant_idx_s = '0;
        end
    end

    // Next-state: lock on any presented beat that is not a completing EOM
    always_comb begin
        state_nxt_s  = state_r;
        owner_nxt_s  = owner_r;
        rr_ptr_nxt_s = rr_ptr_r;
        case (state_r)
            IDLE: begin
                if (out_valid_s) begin
                    if (accept_s && eom_s) begin
                        rr_ptr_nxt_s = wrap_inc(grant_idx_s);
                    end else begin
                        state_nxt_s = LOCKED;
                        owner_nxt_s = grant_idx_s;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOCKED: begin
                if (accept_s && eom_s) begin
                    state_nxt_s  = IDLE;
                    rr_ptr_nxt_s = wrap_inc(owner_r);
                end else begin
                    state_nxt_s = LOCKED;
                end
            end
            default: begin
                state_nxt_s  = IDLE;
                owner_nxt_s  = '0;
                rr_ptr_nxt_s = '0;
            end
        endcase
    end

    // Output mux and handshake: AND-OR select of the granted requester
    always_comb begin
        umi_out_cmd     = '0;
        umi_out_dstaddr = '0;
        umi_out_srcaddr = '0;
        umi_out_data    = '0;
        for (int i = 0; i < N; i++) begin
            umi_out_cmd     = umi_out_cmd     | (umi_req_cmd[i*CW +: CW]     & {CW{grant_s[i]}});
            umi_out_dstaddr = umi_out_dstaddr | (umi_req_dstaddr[i*AW +: AW] & {AW{grant_s[i]}});
            umi_out_srcaddr = umi_out_srcaddr | (umi_req_srcaddr[i*AW +: AW] & {AW{grant_s[i]}});
            umi_out_data    = umi_out_data    | (umi_req_data[i*DW +: DW]    & {DW{grant_s[i]}});
        end
        out_valid_s   = |(grant_s & umi_req_valid);
        accept_s      = out_valid_s & umi_out_ready;
        eom_s         = |(grant_s & eom_vec_s);
        umi_out_valid = out_valid_s;
        umi_req_ready = grant_s & {N{umi_out_ready}};
        arb_grant     = grant_s;
        arb_locked    = (state_r == LOCKED);
    end

endmodule

// File: tb/tb_umi_arbiter_rr.sv
// Self-checking bench for umi_arbiter_rr: vector table, directed corner
// sequences and randomized traffic against a packet-level reference model.
module tb_umi_arbiter_rr;

    localparam int N  = 4;
    localparam int CW = 32;
    localparam int AW = 64;
    localparam int DW = 256;
`ifdef UMI_ARB_QOS_EN
    localparam bit QOS_EN = 1'b1;
`else
    localparam bit QOS_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            nreset;
    logic [N-1:0]    valid;
    logic [N*CW-1:0] cmd;
    logic [N*AW-1:0] dst;
    logic [N*AW-1:0] src;
    logic [N*DW-1:0] data;
    logic            out_ready;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic [CW-1:0]   out_cmd;
    logic [AW-1:0]   out_dst;
    logic [AW-1:0]   out_src;
    logic [DW-1:0]   out_data;
    logic [N-1:0]    grant;
    logic            locked;

    always #5 clk = ~clk;

    umi_arbiter_rr #(.N(N), .CW(CW), .AW(AW), .DW(DW)) dut (
        .umi_in_clk      (clk),
        .umi_in_nreset   (nreset),
        .umi_req_valid   (valid),
        .umi_req_cmd     (cmd),
        .umi_req_dstaddr (dst),
        .umi_req_srcaddr (src),
        .umi_req_data    (data),
        .umi_req_ready   (req_ready),
        .umi_out_valid   (out_valid),
        .umi_out_cmd     (out_cmd),
        .umi_out_dstaddr (out_dst),
        .umi_out_srcaddr (out_src),
        .umi_out_data    (out_data),
        .umi_out_ready   (out_ready),
        .arb_grant       (grant),
        .arb_locked      (locked)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: packet owner (-1 = channel free), next start position,
    // cycles since reset release (saturates at 2)
    int m_owner;
    int m_ptr;
    int m_init;
    int m_g;

    // Outputs sampled by the last step_cycle
    logic [N-1:0] s_grant;
    logic         s_valid;
    logic         s_locked;

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] eom;
        logic         rdy;
        logic [N-1:0] g;
        logic         v;
        logic         l;
    } vec_t;
    vec_t tbl [13];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] mk_cmd(input logic eom, input logic [3:0] qos);
        logic [CW-1:0] c;
        c        = $urandom;
        c[22]    = eom;
        c[19:16] = qos;
        return c;
    endfunction

    task automatic set_req(input int i, input logic v, input logic eom, input logic [3:0] qos);
        valid[i]         = v;
        cmd[i*CW +: CW]  = mk_cmd(eom, qos);
        dst[i*AW +: AW]  = {$urandom, $urandom};
        src[i*AW +: AW]  = {$urandom, $urandom};
        for (int k = 0; k < DW / 32; k++) data[i*DW + k*32 +: 32] = $urandom;
    endtask

    function automatic int qos_of(input int j);
        return int'(cmd[j*CW + 16 +: 4]);
    endfunction

    // Expected grant index from the arbitration rules, -1 for none
    function automatic int model_pick();
        int best;
        int j;
        best = 0;
        if (m_init < 2) return -1;
        if (m_owner >= 0) return m_owner;
        for (int i = 0; i < N; i++)
            if (QOS_EN && valid[i] && qos_of(i) > best) best = qos_of(i);
        for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (valid[j] && (!QOS_EN || qos_of(j) == best)) return j;
        end
        return -1;
    endfunction

    // One clock: check outputs mid-cycle against the model, then advance the model
    task automatic step_cycle();
        logic [N-1:0] eg;
        logic         ev;
        logic         acc;
        @(negedge clk);
        m_g = model_pick();
        eg  = '0;
        if (m_g >= 0) eg[m_g] = 1'b1;
        ev = (m_g >= 0) && valid[m_g];
        s_grant  = grant;
        s_valid  = out_valid;
        s_locked = locked;
        chk("grant", grant, eg);
        chk("out_valid", out_valid, ev);
        chk("locked", locked, m_owner >= 0);
        chk("req_ready", req_ready, eg & {N{out_ready}});
        if (ev) begin
            chk("out_cmd", out_cmd, cmd[m_g*CW +: CW]);
            chk("out_dstaddr", out_dst, dst[m_g*AW +: AW]);
            chk("out_srcaddr", out_src, src[m_g*AW +: AW]);
            chk("out_data", out_data, data[m_g*DW +: DW]);
        end
        @(posedge clk);
        if (m_init < 2) begin
            m_init++;
        end else if (m_g >= 0) begin
            acc = valid[m_g] && out_ready;
            if (acc && cmd[m_g*CW + 22]) begin
                m_owner = -1;
                m_ptr   = (m_g + 1) % N;
            end else if (valid[m_g]) begin
                m_owner = m_g;
            end
        end
        #1;
    endtask

    // Asynchronous reset pulse with output checks while it is held
    task automatic do_reset();
        nreset  = 1'b0;
        m_owner = -1;
        m_ptr   = 0;
        m_init  = 0;
        #2;
        chk("rst_grant", grant, '0);
        chk("rst_valid", out_valid, '0);
        chk("rst_ready", req_ready, '0);
        chk("rst_locked", locked, '0);
        chk("rst_cmd", out_cmd, '0);
        chk("rst_data", out_data, '0);
        @(posedge clk);
        #1;
        nreset = 1'b1;
    endtask

    task automatic idle_init();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b1, 4'd0);
        out_ready = 1'b1;
        step_cycle();
        step_cycle();
    endtask

    logic [CW-1:0] saved_cmd;
    logic [DW-1:0] saved_data;

    initial begin
        tbl[0]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b0};
        tbl[1]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 1'b0};
        tbl[2]  = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 1'b0};
        tbl[3]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 1'b0};
        tbl[4]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b0};
        tbl[5]  = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0};
        tbl[6]  = '{4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b1, 1'b0};
        tbl[7]  = '{4'b0110, 4'b0000, 1'b1, 4'b0100, 1'b1, 1'b1};
        tbl[8]  = '{4'b0010, 4'b0000, 1'b1, 4'b0100, 1'b0, 1'b1};
        tbl[9]  = '{4'b0110, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b1};
        tbl[10] = '{4'b0011, 4'b0011, 1'b1, 4'b0001, 1'b1, 1'b0};
        tbl[11] = '{4'b0011, 4'b0011, 1'b1, 4'b0010, 1'b1, 1'b0};
        tbl[12] = '{4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b0};

        nreset    = 1'b1;
        valid     = '0;
        cmd       = '0;
        dst       = '0;
        src       = '0;
        data      = '0;
        out_ready = 1'b0;
        m_owner   = -1;
        m_ptr     = 0;
        m_init    = 0;
        @(posedge clk);
        #1;

        // Reset and init gating: all requesting, nothing granted for two cycles
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, 4'd0);
        do_reset();
        out_ready = 1'b1;
        step_cycle();
        chk("init0_grant", s_grant, 4'b0000);
        step_cycle();
        chk("init1_grant", s_grant, 4'b0000);

        // Vector table
        for (int r = 0; r < 13; r++) begin
            for (int i = 0; i < N; i++) set_req(i, tbl[r].valid[i], tbl[r].eom[i], 4'd0);
            out_ready = tbl[r].rdy;
            step_cycle();
            chk($sformatf("tbl%0d_grant", r), s_grant, tbl[r].g);
            chk($sformatf("tbl%0d_valid", r), s_valid, tbl[r].v);
            chk($sformatf("tbl%0d_locked", r), s_locked, tbl[r].l);
        end

        // 3-beat packet on req1 holds off req2 for exactly three beats
        do_reset();
        idle_init();
        set_req(2, 1'b1, 1'b1, 4'd0);
        for (int b = 0; b < 3; b++) begin
            set_req(1, 1'b1, (b == 2), 4'd0);
            step_cycle();
            chk($sformatf("pkt3_beat%0d", b), s_grant, 4'b0010);
        end
        set_req(1, 1'b0, 1'b1, 4'd0);
        step_cycle();
        chk("pkt3_req2", s_grant, 4'b0100);

        // Stalled first beat on req0 is never swapped for req3
        do_reset();
        idle_init();
        set_req(0, 1'b1, 1'b1, 4'd0);
        saved_cmd  = cmd[CW-1:0];
        saved_data = data[DW-1:0];
        out_ready  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) set_req(3, 1'b1, 1'b1, 4'd0);
            step_cycle();
            chk($sformatf("stall%0d_grant", c), s_grant, 4'b0001);
            chk($sformatf("stall%0d_cmd", c), out_cmd, saved_cmd);
            chk($sformatf("stall%0d_data", c), out_data, saved_data);
        end
        out_ready = 1'b1;
        step_cycle();
        chk("stall_release", s_grant, 4'b0001);
        set_req(0, 1'b0, 1'b1, 4'd0);
        step_cycle();
        chk("stall_next", s_grant, 4'b1000);

        // Reset while locked on req2 drops the lock; req0 first afterwards
        do_reset();
        idle_init();
        set_req(2, 1'b1, 1'b0, 4'd0);
        step_cycle();
        step_cycle();
        chk("lock2_locked", s_locked, 1'b1);
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, 4'd0);
        do_reset();
        step_cycle();
        step_cycle();
        step_cycle();
        chk("post_rst_grant", s_grant, 4'b0001);

        // QoS selection: req0 QoS 1 versus req2 QoS 7
        do_reset();
        idle_init();
        set_req(0, 1'b1, 1'b1, 4'd1);
        set_req(2, 1'b1, 1'b1, 4'd7);
        step_cycle();
        chk("qos_first", s_grant, QOS_EN ? 4'b0100 : 4'b0001);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++)
                set_req(i, ($urandom_range(1) == 1), ($urandom_range(2) == 0), 4'($urandom_range(7)));
            out_ready = ($urandom_range(3) != 0);
            step_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
